// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with arbitrary (non power-of-two) depth.
// The head entry is always presented on dataout; it reads 0 while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       pull,
    output logic [WIDTH-1:0]           dataout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_acc, pull_acc;

    // Explicit wrap at DEPTH-1 so non power-of-two depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign dataout  = empty ? '0 : mem_q[rd_ptr_q];

    // When full, a simultaneous pull frees the head slot for the incoming word.
    assign push_acc = push && (!full || pull);
    assign pull_acc = pull && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pull_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_acc && !pull_acc) begin
            count_d = count_q + CW'(1);
        end else if (pull_acc && !push_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; dataout gating by empty hides stale entries.
    always_ff @(posedge clk) begin
        if (rst && push_acc) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized checks of sync_fifo against a queue-based reference model.
module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 15;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pull = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic [WIDTH-1:0] dataout;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] model_q[$];

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .datain  (datain),
        .pull    (pull),
        .dataout (dataout),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_dout;
        exp_dout = (model_q.size() > 0) ? model_q[0] : '0;
        chk({tag, ".count"},   64'(count),   64'(model_q.size()));
        chk({tag, ".full"},    64'(full),    64'(model_q.size() == DEPTH));
        chk({tag, ".empty"},   64'(empty),   64'(model_q.size() == 0));
        chk({tag, ".dataout"}, 64'(dataout), 64'(exp_dout));
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic ps, input logic pl,
                       input logic [WIDTH-1:0] d);
        bit do_push, do_pull;
        rst = r; push = ps; pull = pl; datain = d;
        @(posedge clk);
        #1;
        if (!r) begin
            model_q.delete();
        end else begin
            do_pull = pl && (model_q.size() > 0);
            do_push = ps && ((model_q.size() < DEPTH) || pl);
            if (do_pull) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        check_all(tag);
    endtask

    initial begin
        // Reset and idle
        for (int i = 0; i < 3; i++) cyc("reset", 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) cyc("idle", 1'b1, 1'b0, 1'b0, '0);

        // Fill then drain
        cyc("fill", 1'b1, 1'b1, 1'b0, 32'h12153524);
        cyc("fill", 1'b1, 1'b1, 1'b0, 32'hC0895E81);
        for (int i = 2; i < DEPTH; i++) cyc("fill", 1'b1, 1'b1, 1'b0, $urandom);
        chk("filled.full", 64'(full), 64'(1));
        for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b1, 1'b0, 1'b1, '0);
        chk("drained.empty", 64'(empty), 64'(1));

        // Push while full is ignored
        for (int i = 0; i < DEPTH; i++) cyc("fill2", 1'b1, 1'b1, 1'b0, $urandom);
        cyc("push_full", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        cyc("push_full", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        for (int i = 0; i < DEPTH; i++) cyc("drain2", 1'b1, 1'b0, 1'b1, '0);

        // Pull while empty, then push+pull while empty
        cyc("pull_empty", 1'b1, 1'b0, 1'b1, '0);
        cyc("pull_empty", 1'b1, 1'b0, 1'b1, '0);
        cyc("pp_empty", 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5);
        chk("pp_empty.word", 64'(dataout), 64'(32'hA5A5A5A5));
        cyc("pp_empty_drain", 1'b1, 1'b0, 1'b1, '0);

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) cyc("wrap_push10", 1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 10; i++) cyc("wrap_pull10", 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) cyc("wrap_push15", 1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < DEPTH; i++) cyc("wrap_pull15", 1'b1, 1'b0, 1'b1, '0);

        // Full with push+pull every cycle, then reset mid-stream
        for (int i = 0; i < DEPTH; i++) cyc("fill3", 1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 20; i++) cyc("pp_full", 1'b1, 1'b1, 1'b1, $urandom);
        chk("pp_full.count", 64'(count), 64'(DEPTH));
        cyc("pp_full_rst", 1'b0, 1'b1, 1'b1, $urandom);
        chk("mid_rst.empty", 64'(empty), 64'(1));
        chk("mid_rst.count", 64'(count), 64'(0));
        for (int i = 0; i < DEPTH; i++) cyc("pp_after_rst", 1'b1, 1'b1, 1'b1, $urandom);

        // Randomized traffic with varying fill bias and rare resets
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            cyc("random",
                ($urandom_range(0, 99) != 0),
                ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
                ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
                $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
